hazard_detection: RTL and testbench

Stall and flush controller for the 5-stage MIPS pipeline; the consumer-side counterpart of the forwarding unit. Keeps its own two-deep shadow of the destination registers of in-flight instructions in EX and MEM. Decides every cycle whether the instruction in ID can advance or needs a bubble, and flushes IF/ID on a taken branch. Branches resolve in ID; everything forwarding cannot cover, this block stalls.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_detection_if.sv | 35 +++
 rtl/hazard_shadow_stage.sv | 28 ++
 rtl/hazard_detection.sv | 137 +++++++++++++
 tb/tb_hazard_detection.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: shadow slot record, FSM states, $0 index.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package hazard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic       vld;  // slot holds a real instruction, not a bubble
    logic [4:0] rd;   // destination register
    logic       wr;   // instruction writes rd
    logic       ld;   // instruction is a load (result late)
  } shadow_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL1 = 2'd1,
    ST_STALL2 = 2'd2
  } hz_state_e;

  // True when slot s produces source r and that source is actually read.
  // Writes to $0 are discarded by the register file, so they never match.
  function automatic logic slot_match(shadow_t s, logic [4:0] r, logic use_r);
    return use_r && s.vld && s.wr && (s.rd != REG_ZERO) && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_detection_if.sv
// ID-stage operand/control view in, pipeline hold/flush controls out.
// Latency: n/a (signal bundle only).
// Backpressure: freeze is the external hold; pc_write/if_id_write are the stall outputs.
interface hazard_detection_if;
  logic       freeze;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_branch;
  logic [4:0] id_dest;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       branch_taken;
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_flush;
  logic       if_id_flush;
  logic       stall_err;

  // Controller side.
  modport slave (
    input  freeze, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
           id_dest, id_reg_write, id_mem_read, branch_taken,
    output pc_write, if_id_write, id_ex_flush, if_id_flush, stall_err
  );

  // Pipeline side.
  modport master (
    output freeze, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
           id_dest, id_reg_write, id_mem_read, branch_taken,
    input  pc_write, if_id_write, id_ex_flush, if_id_flush, stall_err
  );
endinterface

// File: rtl/hazard_shadow_stage.sv
// One shadow slot register tracking an in-flight instruction (EX or MEM copy).
// Latency: 1 cycle from load_dat to slot_q.
// Backpressure: en low holds the slot (pipeline frozen).
module hazard_shadow_stage
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  shadow_t load_dat,
  output shadow_t slot_q
);

  shadow_t slot_d;

  // Next slot value: follow the pipeline when enabled, otherwise hold.
  always_comb begin
    slot_d = slot_q;
    if (en) slot_d = load_dat;
  end

  // Slot register; reset empties it.
  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

endmodule

// File: rtl/hazard_detection.sv
// Stall/flush controller for ID: load-use and branch operand hazards, taken-branch squash.
// Latency: 0 cycles, controls are combinational from ID inputs and shadow state.
// Backpressure: freeze zeroes all controls and holds shadows/FSM; optional HAZARD_STATS_EN adds counters.
module hazard_detection
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  hazard_detection_if.slave  hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  shadow_t   ex_q;
  shadow_t   mem_q;
  shadow_t   ex_load;
  logic      shift_en;
  logic      ex_hit;
  logic      mem_hit;
  logic      stall;
  hz_state_e state_q, state_d;
  logic      err_q, err_d;

  assign shift_en = ~hz.freeze;

  // Hazard rules: EX load feeding any consumer, or any EX/MEM producer a branch
  // cannot get forwarded in ID (ALU result in EX, load result in EX or MEM).
  always_comb begin
    ex_hit  = slot_match(ex_q,  hz.id_rs, hz.id_use_rs) | slot_match(ex_q,  hz.id_rt, hz.id_use_rt);
    mem_hit = slot_match(mem_q, hz.id_rs, hz.id_use_rs) | slot_match(mem_q, hz.id_rt, hz.id_use_rt);
    stall   = hz.id_valid & ((ex_q.ld & ex_hit)
                           | (hz.id_branch & ex_hit & ~ex_q.ld)
                           | (hz.id_branch & ((ex_hit & ex_q.ld) | (mem_hit & mem_q.ld))));
  end

  // Pipeline controls; a freeze overrides everything.
  always_comb begin
    hz.pc_write    = 1'b0;
    hz.if_id_write = 1'b0;
    hz.id_ex_flush = 1'b0;
    hz.if_id_flush = 1'b0;
    if (!hz.freeze) begin
      hz.pc_write    = ~stall;
      hz.if_id_write = ~stall;
      hz.id_ex_flush = stall;
      hz.if_id_flush = hz.id_valid & hz.id_branch & hz.branch_taken & ~stall;
    end
  end

  // A stalled ID instruction does not advance, so EX receives a bubble.
  always_comb begin
    ex_load     = '0;
    ex_load.vld = hz.id_valid & ~stall;
    ex_load.rd  = hz.id_dest;
    ex_load.wr  = hz.id_reg_write;
    ex_load.ld  = hz.id_mem_read;
  end

  hazard_shadow_stage u_ex (
    .clk      (clk),
    .rst      (rst),
    .en       (shift_en),
    .load_dat (ex_load),
    .slot_q   (ex_q)
  );

  hazard_shadow_stage u_mem (
    .clk      (clk),
    .rst      (rst),
    .en       (shift_en),
    .load_dat (ex_q),
    .slot_q   (mem_q)
  );

  // Consecutive-stall watchdog: a third stalled unfrozen cycle latches stall_err.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (shift_en) begin
      if (stall) begin
        unique case (state_q)
          ST_RUN:    state_d = ST_STALL1;
          ST_STALL1: state_d = ST_STALL2;
          ST_STALL2: begin
            state_d = ST_STALL2;
            err_d   = 1'b1;
          end
          default:   state_d = ST_RUN;
        endcase
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  // Watchdog state register; only reset clears the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign hz.stall_err = err_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Event counters, wrapping naturally at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, shift_en & stall};
    flush_count_d  = flush_count_q  + {31'd0, hz.if_id_flush};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_detection.sv
// Bench for hazard_detection: scripted pipeline sequences, random run against a model.
// Latency: outputs sampled 1 time unit after inputs settle, before the next rising edge.
// Backpressure: freeze exercised both in scripted rows and randomly.
module tb_hazard_detection;
  import hazard_pkg::*;

  logic clk;
  logic rst;
  hazard_detection_if hif ();
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  hazard_detection dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // exp = {pc_write, if_id_write, id_ex_flush, if_id_flush, stall_err}
  typedef struct {
    logic       frz, vld;
    logic [4:0] rs, rt;
    logic       urs, urt, br;
    logic [4:0] dst;
    logic       rw, mr, tk;
    logic [4:0] exp;
  } vec_t;

  function automatic vec_t v(input logic frz, input logic vld, input logic [4:0] rs,
                             input logic [4:0] rt, input logic urs, input logic urt,
                             input logic br, input logic [4:0] dst, input logic rw,
                             input logic mr, input logic tk, input logic [4:0] exp);
    vec_t r;
    r.frz = frz; r.vld = vld; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.br = br; r.dst = dst; r.rw = rw; r.mr = mr; r.tk = tk; r.exp = exp;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    hif.freeze       = x.frz;
    hif.id_valid     = x.vld;
    hif.id_rs        = x.rs;
    hif.id_rt        = x.rt;
    hif.id_use_rs    = x.urs;
    hif.id_use_rt    = x.urt;
    hif.id_branch    = x.br;
    hif.id_dest      = x.dst;
    hif.id_reg_write = x.rw;
    hif.id_mem_read  = x.mr;
    hif.branch_taken = x.tk;
  endtask

  function automatic logic [4:0] outs();
    return {hif.pc_write, hif.if_id_write, hif.id_ex_flush, hif.if_id_flush, hif.stall_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one ID cycle and check the combinational controls before the edge.
  task automatic step(input string name, input vec_t x);
    @(negedge clk);
    drive(x);
    #1;
    chk(name, 32'(outs()), 32'(x.exp));
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct { bit valid; int dest; bit writes; bit load; } prod_t;
  prod_t inflight[$];   // [0] issued last cycle, [1] the one before
  int    m_consec;
  bit    m_err;
  int unsigned m_stalls, m_flushes;

  function automatic bit produces(prod_t p, int r);
    return p.valid && p.writes && p.dest != 0 && p.dest == r;
  endfunction

  task automatic model_reset();
    prod_t e;
    e = '{valid: 0, dest: 0, writes: 0, load: 0};
    inflight.delete();
    inflight.push_back(e);
    inflight.push_back(e);
    m_consec = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  function automatic bit model_stall(vec_t x);
    bit near, far;
    near = (x.urs && produces(inflight[0], int'(x.rs))) || (x.urt && produces(inflight[0], int'(x.rt)));
    far  = (x.urs && produces(inflight[1], int'(x.rs))) || (x.urt && produces(inflight[1], int'(x.rt)));
    // A branch compares in ID, so any producer one ahead blocks it; a load
    // blocks a branch for as long as it sits in either of the two stages.
    return x.vld && ((near && inflight[0].load) || (x.br && near) || (x.br && far && inflight[1].load));
  endfunction

  function automatic logic [4:0] model_out(vec_t x);
    bit s;
    s = model_stall(x);
    if (x.frz) return {4'b0000, m_err};
    return {~s, ~s, s, x.vld & x.br & x.tk & ~s, m_err};
  endfunction

  task automatic model_clock(input bit r, input vec_t x);
    bit s;
    prod_t p;
    if (r) begin
      model_reset();
    end else if (!x.frz) begin
      s = model_stall(x);
      p = '{valid: x.vld && !s, dest: int'(x.dst), writes: x.rw, load: x.mr};
      inflight.push_front(p);
      void'(inflight.pop_back());
      if (s) begin
        m_consec++;
        m_stalls++;
        if (m_consec >= 3) m_err = 1;
      end else begin
        m_consec = 0;
      end
      if (x.vld && x.br && x.tk && !s) m_flushes++;
    end
  endtask

  vec_t tbl[$];
  vec_t nop, x;

  initial begin
    nop = v(0,0,0,0,0,0,0,0,0,0,0,5'b00000);
    rst = 1'b1;
    drive(nop);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs()), 32'(5'b11000));
`ifdef HAZARD_STATS_EN
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    chk("reset_flush_count", flush_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    //          frz vld rs rt urs urt br dst rw mr tk  exp
    tbl.push_back(v(0,0, 0,0, 0,0,0, 0,0,0,0, 5'b11000)); // idle after reset
    tbl.push_back(v(0,1, 1,0, 1,0,0, 2,1,1,0, 5'b11000)); // lw $2
    tbl.push_back(v(0,1, 2,4, 1,1,0, 3,1,0,0, 5'b00100)); // add $3,$2,$4 load-use
    tbl.push_back(v(0,1, 2,4, 1,1,0, 3,1,0,0, 5'b11000)); // add advances
    tbl.push_back(v(0,1, 8,0, 1,0,0, 0,1,1,0, 5'b11000)); // lw $0
    tbl.push_back(v(0,1, 0,4, 1,1,0, 3,1,0,0, 5'b11000)); // add $3,$0,$4: no stall
    tbl.push_back(v(0,0, 0,0, 0,0,0, 0,0,0,0, 5'b11000)); // nop
    tbl.push_back(v(0,1, 1,1, 1,1,0, 5,1,0,0, 5'b11000)); // add $5,$1,$1
    tbl.push_back(v(0,1, 5,6, 1,1,1, 0,0,0,1, 5'b00100)); // beq $5,$6 after ALU
    tbl.push_back(v(0,1, 5,6, 1,1,1, 0,0,0,1, 5'b11010)); // taken: one flush
    tbl.push_back(v(0,0, 0,0, 0,0,0, 0,0,0,0, 5'b11000)); // squashed slot
    tbl.push_back(v(0,1, 1,0, 1,0,0, 7,1,1,0, 5'b11000)); // lw $7
    tbl.push_back(v(0,1, 7,0, 1,1,1, 0,0,0,1, 5'b00100)); // beq $7,$0 stall 1
    tbl.push_back(v(0,1, 7,0, 1,1,1, 0,0,0,1, 5'b00100)); // stall 2 (load in MEM)
    tbl.push_back(v(0,1, 7,0, 1,1,1, 0,0,0,1, 5'b11010)); // resolves, flush
    tbl.push_back(v(0,0, 0,0, 0,0,0, 0,0,0,0, 5'b11000)); // no stall_err after 2
    tbl.push_back(v(0,1, 1,0, 1,0,0, 2,1,1,0, 5'b11000)); // lw $2
    tbl.push_back(v(1,1, 2,4, 1,1,0, 3,1,0,0, 5'b00000)); // frozen load-use
    tbl.push_back(v(1,1, 2,4, 1,1,0, 3,1,0,0, 5'b00000));
    tbl.push_back(v(1,1, 2,4, 1,1,0, 3,1,0,0, 5'b00000));
    tbl.push_back(v(0,1, 2,4, 1,1,0, 3,1,0,0, 5'b00100)); // shadow held: stall now
    tbl.push_back(v(0,1, 2,4, 1,1,0, 3,1,0,0, 5'b11000)); // single stall cycle
    tbl.push_back(v(0,0, 0,0, 0,0,0, 0,0,0,0, 5'b11000));

    foreach (tbl[i]) step($sformatf("tbl_row%0d", i), tbl[i]);

    // Reset while the branch-after-load stall is in progress.
    step("rst_seq_lw",    v(0,1, 1,0, 1,0,0, 9,1,1,0, 5'b11000));
    step("rst_seq_stall", v(0,1, 9,0, 1,1,1, 0,0,0,1, 5'b00100));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_seq_during", 32'(outs()), 32'(5'b00100));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_seq_after", 32'(outs()), 32'(5'b11010));
`ifdef HAZARD_STATS_EN
    chk("rst_seq_stall_cycles", stall_cycles, 32'd0);
    chk("rst_seq_flush_count", flush_count, 32'd0);
`endif

    // Randomised run against the reference model (small register range for hits).
    for (int c = 0; c < 3000; c++) begin
      bit r;
      logic [4:0] exp;
      @(negedge clk);
      r = (c == 0) || ($urandom_range(63) == 0);
      x = v($urandom_range(7) == 0, $urandom_range(3) != 0,
            5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(3) == 0,
            5'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 5'b00000);
      rst = r;
      drive(x);
      #1;
      if (c != 0) begin
        exp = model_out(x);
        chk($sformatf("rand_cyc%0d", c), 32'(outs()), 32'(exp));
`ifdef HAZARD_STATS_EN
        chk($sformatf("rand_stalls%0d", c), stall_cycles, m_stalls);
        chk($sformatf("rand_flushes%0d", c), flush_count, m_flushes);
`endif
      end
      model_clock(r, x);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(nop);

    // Pin EX to a constant load of $9 so a reader of $9 stalls indefinitely.
    @(negedge clk);
    force dut.ex_q = shadow_t'{1'b1, 5'd9, 1'b1, 1'b1};
    x = v(0,1, 9,0, 1,0,0, 3,1,0,0, 5'b00100);
    step("err_stall1", x);
    step("err_stall2", x);
    step("err_stall3", x);
    x.exp = 5'b00101;
    step("err_stall4_set", x);
    @(negedge clk);
    release dut.ex_q;
    drive(nop);
    #1;
    chk("err_sticky1", 32'(outs()), 32'(5'b11001));
    step("err_sticky2", v(0,0, 0,0, 0,0,0, 0,0,0,0, 5'b11001));
    step("err_sticky_frz", v(1,0, 0,0, 0,0,0, 0,0,0,0, 5'b00001));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(nop);
    #1;
    chk("err_cleared_by_rst", 32'(outs()), 32'(5'b11000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
